// File: rtl/decimal_codec_pkg.sv
// Shared types for the decimal encoder/decoder pair: digit count, code width,
// one-hot and binary code types, and the decoder state encoding.
package decimal_codec_pkg;

  localparam int DIGITS = 10;
  localparam int BIN_W  = 4;

  typedef logic [DIGITS-1:0] onehot_t;
  typedef logic [BIN_W-1:0]  bin_t;

  typedef enum logic {
    IDLE,
    HOLD
  } dec_state_e;

endpackage

// File: rtl/bin_to_onehot10.sv
// Combinational map from a 4-bit digit code to a 10-bit one-hot line.
// Codes 10..15 produce an all-zero one-hot and raise invalid.
module bin_to_onehot10
  import decimal_codec_pkg::*;
(
  input  logic [BIN_W-1:0]  code,
  output logic [DIGITS-1:0] onehot,
  output logic              invalid
);

  // One line per digit; out-of-range codes match no line.
  always_comb begin
    onehot  = '0;
    invalid = (code >= bin_t'(DIGITS));
    for (int k = 0; k < DIGITS; k++) begin
      onehot[k] = (code == bin_t'(k));
    end
  end

endmodule

// File: rtl/binary_to_decimal_decoder.sv
// Accepts digit codes over valid/ready, drives the matching one-hot decimal
// line for HOLD_CYCLES cycles, and flags/counts out-of-range codes.
//
// state | meaning
// IDLE  | no digit shown, ready for a code every cycle
// HOLD  | one-hot digit driven; ready again only on its final hold cycle
module binary_to_decimal_decoder
  import decimal_codec_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIN_W-1:0]     binary_input,
  output logic [DIGITS-1:0]    decimal_output,
  output logic                 out_valid,
  output logic                 out_last,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [7:0] LAST_CNT = 8'(HOLD_CYCLES - 1);

  dec_state_e          state;
  logic [7:0]          hold_cnt;
  logic [DIGITS-1:0]   dec_onehot;
  logic                dec_invalid;
  logic                accept;
  logic                acc_valid;
  logic                acc_invalid;
  logic [7:0]          hold_cnt_inc;

  bin_to_onehot10 u_dec (
    .code    (binary_input),
    .onehot  (dec_onehot),
    .invalid (dec_invalid)
  );

  // Ready depends only on state and the hold counter, never on in_valid.
  assign in_ready     = (state == IDLE) || (hold_cnt == LAST_CNT);
  assign accept       = in_valid && in_ready;
  assign acc_valid    = accept && !dec_invalid;
  assign acc_invalid  = accept && dec_invalid;
  assign hold_cnt_inc = hold_cnt + 8'd1;

  // Hold FSM with registered one-hot output, last flag and error tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      hold_cnt       <= '0;
      decimal_output <= '0;
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      err_pulse      <= 1'b0;
      err_count      <= '0;
    end else begin
      err_pulse <= acc_invalid;
      if (acc_invalid && (err_count != '1)) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end

      if (acc_valid) begin
        // Fresh digit, either from IDLE or back-to-back on the last hold cycle.
        state          <= HOLD;
        hold_cnt       <= '0;
        decimal_output <= dec_onehot;
        out_valid      <= 1'b1;
        out_last       <= (LAST_CNT == 8'd0);
      end else if (state == HOLD) begin
        if (hold_cnt == LAST_CNT) begin
          state          <= IDLE;
          hold_cnt       <= '0;
          decimal_output <= '0;
          out_valid      <= 1'b0;
          out_last       <= 1'b0;
        end else begin
          hold_cnt <= hold_cnt_inc;
          out_last <= (hold_cnt_inc == LAST_CNT);
        end
      end
    end
  end

endmodule
